// File: rtl/digit_entry.sv
// digit_entry
// Lets the player edit a decimal number one digit at a time using five board
// buttons, then turns the digits into a binary value when OK is pressed and
// hands that value to game control over a valid/ready handshake.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              entry enable; while low no button press is acted upon
//   btn_up/down     raw buttons: increment / decrement the digit at the cursor
//   btn_left/right  raw buttons: move cursor toward more / less significant digit
//   btn_ok          raw button: confirm and convert
//   value_ready     consumer accepts value_out
//   value_out       composed binary value (held until the next conversion)
//   value_valid     value_out is valid
//   digits_out      BCD digit buffer, digit 0 (least significant) in [3:0]
//   cursor          index of the selected digit, 0 = least significant
//   busy            high while converting or waiting for the consumer
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int DIGITS          = 6,
    parameter int VALUE_W         = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_ok,
    input  logic                  value_ready,
    output logic [VALUE_W-1:0]    value_out,
    output logic                  value_valid,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [2:0]            cursor,
    output logic                  busy
);

    localparam int NB    = 5;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       TOP_IDX  = 3'(DIGITS - 1);

    // Button slots inside the conditioning vectors
    localparam int B_OK = 0;
    localparam int B_UP = 1;
    localparam int B_DN = 2;
    localparam int B_LT = 3;
    localparam int B_RT = 4;

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] get_digit(input logic [4*DIGITS-1:0] dbuf,
                                             input logic [2:0] pos);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            res = (pos == 3'(k)) ? dbuf[4*k +: 4] : res;
        end
        return res;
    endfunction

    function automatic logic [4*DIGITS-1:0] set_digit(input logic [4*DIGITS-1:0] dbuf,
                                                      input logic [2:0] pos,
                                                      input logic [3:0] val);
        logic [4*DIGITS-1:0] res;
        res = dbuf;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = (pos == 3'(k)) ? val : dbuf[4*k +: 4];
        end
        return res;
    endfunction

    // x*10 as (x<<3)+(x<<1), widened by four bits then truncated back
    function automatic logic [VALUE_W-1:0] mul10(input logic [VALUE_W-1:0] a);
        logic [VALUE_W+3:0] w;
        w = {4'b0000, a};
        w = (w << 3) + (w << 1);
        return w[VALUE_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning: synchronizer, debouncer and press-edge detect
    // ------------------------------------------------------------------
    logic [NB-1:0]    btn_raw_s;
    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    stable_q, stable_d;
    logic [NB-1:0]    press_q, press_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up, btn_ok};

    // Debounce next-state: count while the synced level disagrees with the
    // accepted level; a press is flagged on an accepted 0->1 change only.
    // The tracking itself ignores en so a release while disabled is absorbed.
    always_comb begin
        sync1_d  = btn_raw_s;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = {CNT_W{1'b0}};
                    press_d[i]  = sync2_q[i] & en;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = {CNT_W{1'b0}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Edit / convert / hold control
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [2:0]          cursor_q, cursor_d;
    logic [VALUE_W-1:0]  acc_q, acc_d;
    logic [2:0]          idx_q, idx_d;
    logic [VALUE_W-1:0]  value_q, value_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [3:0]          cur_digit_s;
    logic [3:0]          conv_digit_s;
    logic [VALUE_W-1:0]  step_s;

    assign cur_digit_s  = get_digit(digits_q, cursor_q);
    assign conv_digit_s = get_digit(digits_q, idx_q);
    assign step_s       = mul10(acc_q) + {{(VALUE_W-4){1'b0}}, conv_digit_s};

    // Control next-state. Only one press is honoured per cycle, in the order
    // ok > up > down > left > right; presses outside EDIT are discarded.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cursor_d = cursor_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        value_d  = value_q;
        valid_d  = valid_q;
        case (state_q)
            ST_EDIT: begin
                if (press_q[B_OK]) begin
                    acc_d   = {VALUE_W{1'b0}};
                    idx_d   = TOP_IDX;
                    state_d = ST_CONVERT;
                end else if (press_q[B_UP]) begin
                    digits_d = set_digit(digits_q, cursor_q,
                                         (cur_digit_s == 4'd9) ? 4'd0 : cur_digit_s + 4'd1);
                end else if (press_q[B_DN]) begin
                    digits_d = set_digit(digits_q, cursor_q,
                                         (cur_digit_s == 4'd0) ? 4'd9 : cur_digit_s - 4'd1);
                end else if (press_q[B_LT]) begin
                    cursor_d = (cursor_q == TOP_IDX) ? 3'd0 : cursor_q + 3'd1;
                end else if (press_q[B_RT]) begin
                    cursor_d = (cursor_q == 3'd0) ? TOP_IDX : cursor_q - 3'd1;
                end else begin
                    state_d = ST_EDIT;
                end
            end
            ST_CONVERT: begin
                // Most significant digit first: acc = acc*10 + digit[idx]
                acc_d = step_s;
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    value_d = step_s;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_HOLD: begin
                if (value_ready && valid_q) begin
                    valid_d = 1'b0;
                    state_d = ST_EDIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_EDIT;
            end
        endcase
        busy_d = (state_d != ST_EDIT);
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= {NB{1'b0}};
            sync2_q  <= {NB{1'b0}};
            stable_q <= {NB{1'b0}};
            press_q  <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            state_q  <= ST_EDIT;
            digits_q <= {(4*DIGITS){1'b0}};
            cursor_q <= 3'd0;
            acc_q    <= {VALUE_W{1'b0}};
            idx_q    <= 3'd0;
            value_q  <= {VALUE_W{1'b0}};
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            digits_q <= digits_d;
            cursor_q <= cursor_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign digits_out  = digits_q;
    assign cursor      = cursor_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry
// Self-checking bench for digit_entry with a short debounce window. Directed
// vectors come from a constant table; randomized edit/convert traffic is
// checked against a digit-array model of the player's number.
module tb_digit_entry;

    localparam int DB = 4;
    localparam int ND = 6;
    localparam int VW = 21;

    localparam logic [4:0] M_OK = 5'b00001;
    localparam logic [4:0] M_UP = 5'b00010;
    localparam logic [4:0] M_DN = 5'b00100;
    localparam logic [4:0] M_LT = 5'b01000;
    localparam logic [4:0] M_RT = 5'b10000;

    logic clk = 1'b0;
    logic rst, en, btn_up, btn_down, btn_left, btn_right, btn_ok, value_ready;
    logic [VW-1:0]   value_out;
    logic            value_valid;
    logic [4*ND-1:0] digits_out;
    logic [2:0]      cursor;
    logic            busy;

    digit_entry #(.DEBOUNCE_CYCLES(DB), .DIGITS(ND), .VALUE_W(VW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_ok(btn_ok), .value_ready(value_ready),
        .value_out(value_out), .value_valid(value_valid),
        .digits_out(digits_out), .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the number as an array of decimal digits plus cursor
    int m_dig[ND];
    int m_cur;

    typedef struct {
        logic [4:0]  btn;
        logic [23:0] exp_d;
        logic [2:0]  exp_c;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] v);
        btn_ok    = v[0];
        btn_up    = v[1];
        btn_down  = v[2];
        btn_left  = v[3];
        btn_right = v[4];
    endtask

    function automatic logic [31:0] model_digits();
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    function automatic int model_value();
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            v += m_dig[i] * p;
            p *= 10;
        end
        return v;
    endfunction

    // Clean press of one or more edit buttons; the model applies the one
    // that wins under up > down > left > right.
    task automatic press(input logic [4:0] v);
        set_btns(v);
        repeat (6) tick();
        set_btns(5'b00000);
        repeat (8) tick();
        if (v[1])      m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        else if (v[2]) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
        else if (v[3]) m_cur = (m_cur + 1) % ND;
        else if (v[4]) m_cur = (m_cur + ND - 1) % ND;
    endtask

    task automatic check_edit(input string name);
        chk({name, " digits"}, 32'(digits_out), model_digits());
        chk({name, " cursor"}, 32'(cursor), 32'(m_cur));
    endtask

    // Drive presses until the buffer holds the decimal digits of val
    task automatic goto_value(input int val);
        int t, dl, du, v;
        for (int pos = ND - 1; pos >= 0; pos--) begin
            v = val;
            for (int k = 0; k < pos; k++) v = v / 10;
            t  = v % 10;
            dl = (pos - m_cur + ND) % ND;
            if (dl <= ND / 2) begin
                repeat (dl) press(M_LT);
            end else begin
                repeat (ND - dl) press(M_RT);
            end
            du = (t - m_dig[pos] + 10) % 10;
            if (du <= 5) begin
                repeat (du) press(M_UP);
            end else begin
                repeat (10 - du) press(M_DN);
            end
        end
        check_edit("goto");
    endtask

    // Press ok, check conversion latency/result, then complete the handshake
    task automatic do_convert(input int ready_delay, input bit early, input bit poke_up);
        int exp_v, n;
        bit stable_ok;
        exp_v = model_value();
        value_ready = early;
        btn_ok = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b1) begin
            chk("convert start timeout", 32'(busy), 32'd1);
            btn_ok = 1'b0;
            value_ready = 1'b0;
            repeat (10) tick();
        end else begin
            n = 0;
            while (value_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("convert latency", 32'(n), 32'(ND));
            chk("convert value", 32'(value_out), 32'(exp_v));
            if (early) begin
                tick();
                chk("early ready valid drop", 32'(value_valid), 32'd0);
                chk("early ready busy", 32'(busy), 32'd0);
            end else begin
                stable_ok = 1'b1;
                for (int c = 0; c < ready_delay; c++) begin
                    if (poke_up) btn_up = (c >= 2 && c < 8);
                    tick();
                    if (value_valid !== 1'b1 || value_out !== VW'(exp_v) || busy !== 1'b1)
                        stable_ok = 1'b0;
                end
                btn_up = 1'b0;
                chk("hold stable", 32'(stable_ok), 32'd1);
                value_ready = 1'b1;
                tick();
                chk("ack valid drop", 32'(value_valid), 32'd0);
                chk("ack busy drop", 32'(busy), 32'd0);
            end
            value_ready = 1'b0;
            btn_ok = 1'b0;
            repeat (10) tick();
            check_edit("after convert");
            chk("value retained", 32'(value_out), 32'(exp_v));
        end
    endtask

    initial begin
        int n;
        bit seen;
        logic [4:0] m;

        tbl[0] = '{M_DN, 24'h000000, 3'd0};
        tbl[1] = '{M_DN, 24'h000009, 3'd0};
        tbl[2] = '{M_UP, 24'h000000, 3'd0};
        tbl[3] = '{M_RT, 24'h000000, 3'd5};
        tbl[4] = '{M_UP, 24'h100000, 3'd5};
        tbl[5] = '{M_LT, 24'h100000, 3'd0};
        tbl[6] = '{M_LT, 24'h100000, 3'd1};
        tbl[7] = '{M_DN, 24'h100090, 3'd1};
        tbl[8] = '{M_RT, 24'h100090, 3'd0};
        tbl[9] = '{M_UP, 24'h100091, 3'd0};

        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_cur = 0;
        rst = 1'b1;
        en = 1'b1;
        value_ready = 1'b0;
        set_btns(5'b00000);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset digits", 32'(digits_out), 32'd0);
        chk("reset cursor", 32'(cursor), 32'd0);
        chk("reset value", 32'(value_out), 32'd0);
        chk("reset valid", 32'(value_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        // Debounce: 3-cycle pulse is rejected
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        chk("short pulse ignored", 32'(digits_out), 32'd0);

        // Long hold with a one-cycle dropout gives exactly one press
        btn_up = 1'b1;
        repeat (6) tick();
        btn_up = 1'b0;
        tick();
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        chk("held press once", 32'(digits_out), 32'h000001);
        m_dig[0] = 1;

        // Table-driven edit vectors
        for (int i = 0; i < 10; i++) begin
            press(tbl[i].btn);
            chk($sformatf("vec%0d digits", i), 32'(digits_out), 32'(tbl[i].exp_d));
            chk($sformatf("vec%0d cursor", i), 32'(cursor), 32'(tbl[i].exp_c));
        end

        // Ten ups at one position come back to the starting digit
        repeat (10) press(M_UP);
        chk("up x10 wrap", 32'(digits_out), 32'h100091);

        // Conversions
        goto_value(123456);
        do_convert(2, 1'b0, 1'b0);
        goto_value(999999);
        do_convert(20, 1'b0, 1'b1);
        chk("digits kept after hold", 32'(digits_out), 32'h999999);

        // Up and left together: only the digit changes
        press(M_UP | M_LT);
        check_edit("simultaneous");

        // ok while disabled is ignored, release while disabled makes no edge
        en = 1'b0;
        seen = 1'b0;
        btn_ok = 1'b1;
        repeat (8) begin
            tick();
            if (busy === 1'b1) seen = 1'b1;
        end
        btn_ok = 1'b0;
        repeat (10) begin
            tick();
            if (busy === 1'b1) seen = 1'b1;
        end
        en = 1'b1;
        repeat (4) begin
            tick();
            if (busy === 1'b1) seen = 1'b1;
        end
        chk("en low no convert", 32'(seen), 32'd0);
        do_convert(1, 1'b0, 1'b0);

        // Randomized edits and conversions against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 8) begin
                m = 5'($urandom_range(1, 15)) << 1;
                press(m);
                check_edit($sformatf("rand%0d", it));
            end else begin
                do_convert($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        do_convert(0, 1'b1, 1'b0);

        // Reset at T+3 aborts the conversion
        btn_ok = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("reset test convert start", 32'(busy), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        btn_ok = 1'b0;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (value_valid !== 1'b0) seen = 1'b1;
        end
        chk("rst no valid", 32'(seen), 32'd0);
        chk("rst digits", 32'(digits_out), 32'd0);
        chk("rst cursor", 32'(cursor), 32'd0);
        chk("rst value", 32'(value_out), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
